// File: rtl/lcd_controller_pkg.sv
// Shared definitions for the HD44780 4-bit LCD sequencer: state encodings,
// counter widths, command bytes and the power-on init nibbles.
package lcd_controller_pkg;

  localparam int CNT_W     = 20;
  localparam int NIB_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_PWRUP, ST_INIT, ST_CONFIG, ST_IDLE, ST_WRITE, ST_WAIT
  } state_e;

  // Position within one nibble or byte transfer of INIT/CONFIG/WRITE.
  typedef enum logic [1:0] {
    PH_START, PH_HI, PH_GAP, PH_LO
  } phase_e;

  typedef enum logic [1:0] {
    NW_IDLE, NW_SETUP, NW_PULSE, NW_HOLD
  } nw_state_e;

  localparam logic [7:0] CMD_FUNCTION_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_LINE1        = 8'h80;
  localparam logic [7:0] CMD_LINE2        = 8'hC0;

  localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
  endfunction

  function automatic logic [7:0] config_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNCTION_SET;
      2'd1:    return CMD_ENTRY_MODE;
      2'd2:    return CMD_DISPLAY_ON;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_controller_if.sv
// Byte-write handshake between the CPU (master) and the LCD sequencer (slave).
interface lcd_controller_if;
  logic       iWrite;
  logic       iRS;
  logic [7:0] iData;
  logic       oReady;

  modport master (output iWrite, output iRS, output iData, input oReady);
  modport slave  (input iWrite, input iRS, input iData, output oReady);
endinterface

// File: rtl/lcd_controller_nibble_writer.sv
// lcd_nibble_writer: drives one nibble onto DB[7:4] with RS setup, an E pulse
// and one hold cycle; oDone is high during the hold cycle.
module lcd_nibble_writer
  import lcd_controller_pkg::*;
#(
  parameter int P_SETUP   = 2,
  parameter int P_E_PULSE = 12
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic [3:0] iNibble,
  input  logic       iRS,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic [3:0] oLCD_Data
);

  nw_state_e            state_q;
  logic [NIB_CNT_W-1:0] cnt_q;
  logic                 e_q;
  logic                 rs_q;
  logic [3:0]           data_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= NW_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        NW_IDLE: if (iStart) begin
          data_q  <= iNibble;
          rs_q    <= iRS;
          cnt_q   <= NIB_CNT_W'(P_SETUP - 1);
          state_q <= NW_SETUP;
        end
        NW_SETUP: if (cnt_q == '0) begin
          e_q     <= 1'b1;
          cnt_q   <= NIB_CNT_W'(P_E_PULSE - 1);
          state_q <= NW_PULSE;
        end else begin
          cnt_q <= cnt_q - NIB_CNT_W'(1);
        end
        NW_PULSE: if (cnt_q == '0) begin
          e_q     <= 1'b0;
          state_q <= NW_HOLD;
        end else begin
          cnt_q <= cnt_q - NIB_CNT_W'(1);
        end
        default: state_q <= NW_IDLE;
      endcase
    end
  end

  assign oDone               = (state_q == NW_HOLD);
  assign oLCD_Enabled        = e_q;
  assign oLCD_RegisterSelect = rs_q;
  assign oLCD_Data           = data_q;

endmodule

// File: rtl/lcd_controller.sv
// HD44780 4-bit sequencer: power-up, init, config, then single-byte writes.
// Optional LCD_AUTO_WRAP_EN inserts line-change commands after 16 characters.
module lcd_controller
  import lcd_controller_pkg::*;
#(
  parameter int P_POWERUP    = 750000,
  parameter int P_WAIT_4MS   = 205000,
  parameter int P_WAIT_100US = 5000,
  parameter int P_WAIT_40US  = 2000,
  parameter int P_WAIT_CLEAR = 82000,
  parameter int P_SETUP      = 2,
  parameter int P_E_PULSE    = 12,
  parameter int P_NIBBLE_GAP = 50
) (
  input  logic             Clock,
  input  logic             Reset,
  lcd_controller_if.slave  bus,
  output logic             oLCD_Enabled,
  output logic             oLCD_RegisterSelect,
  output logic             oLCD_ReadWrite,
  output logic             oLCD_StrataFlashControl,
  output logic [3:0]       oLCD_Data
);

  state_e             state_q;
  state_e             src_q;
  phase_e             phase_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         idx_q;
  logic [7:0]         byte_q;
  logic               rs_q;
  logic               ready_q;
`ifdef LCD_AUTO_WRAP_EN
  logic               line_q;
  logic [4:0]         col_q;
`endif

  logic               nib_start;
  logic [3:0]         nib_data;
  logic               nib_done;
  logic [CNT_W-1:0]   wait_load;

  always_comb begin
    nib_start = 1'b0;
    nib_data  = byte_q[7:4];
    case (state_q)
      ST_INIT: begin
        nib_start = (phase_q == PH_START);
        nib_data  = init_nibble(idx_q);
      end
      ST_CONFIG, ST_WRITE: begin
        nib_start = (phase_q == PH_START) || (phase_q == PH_GAP && cnt_q == '0);
        nib_data  = (phase_q == PH_START) ? byte_q[7:4] : byte_q[3:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_load = CNT_W'(P_WAIT_40US - 1);
    if (state_q == ST_INIT) begin
      case (idx_q)
        2'd0:    wait_load = CNT_W'(P_WAIT_4MS - 1);
        2'd1:    wait_load = CNT_W'(P_WAIT_100US - 1);
        default: wait_load = CNT_W'(P_WAIT_40US - 1);
      endcase
    end else if (!rs_q && (byte_q == CMD_CLEAR || byte_q == CMD_HOME)) begin
      wait_load = CNT_W'(P_WAIT_CLEAR - 1);
    end
  end

  // The gap counts from E falling, so the writer's hold cycle is its first cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_PWRUP;
      src_q   <= ST_INIT;
      phase_q <= PH_START;
      cnt_q   <= CNT_W'(P_POWERUP - 1);
      idx_q   <= 2'd0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      ready_q <= 1'b0;
`ifdef LCD_AUTO_WRAP_EN
      line_q  <= 1'b0;
      col_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_PWRUP: if (cnt_q == '0) begin
          state_q <= ST_INIT;
          phase_q <= PH_START;
          idx_q   <= 2'd0;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
        ST_INIT, ST_CONFIG, ST_WRITE: begin
          case (phase_q)
            PH_START: phase_q <= (state_q == ST_INIT) ? PH_LO : PH_HI;
            PH_HI: if (nib_done) begin
              phase_q <= PH_GAP;
              cnt_q   <= CNT_W'(P_NIBBLE_GAP - 2);
            end
            PH_GAP: if (cnt_q == '0) phase_q <= PH_LO;
                    else cnt_q <= cnt_q - CNT_W'(1);
            PH_LO: if (nib_done) begin
              src_q   <= state_q;
              state_q <= ST_WAIT;
              cnt_q   <= wait_load;
            end
          endcase
        end
        ST_WAIT: if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end else begin
          phase_q <= PH_START;
          case (src_q)
            ST_INIT: if (idx_q == 2'd3) begin
              state_q <= ST_CONFIG;
              idx_q   <= 2'd0;
              byte_q  <= config_byte(2'd0);
            end else begin
              state_q <= ST_INIT;
              idx_q   <= idx_q + 2'd1;
            end
            ST_CONFIG: if (idx_q == 2'd3) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_CONFIG;
              idx_q   <= idx_q + 2'd1;
              byte_q  <= config_byte(idx_q + 2'd1);
            end
            default: begin
`ifdef LCD_AUTO_WRAP_EN
              // An inserted 0x80/0xC0 reloads line/column through the bit7 path below.
              if (rs_q && col_q == 5'd15) begin
                state_q <= ST_WRITE;
                rs_q    <= 1'b0;
                byte_q  <= line_q ? CMD_LINE1 : CMD_LINE2;
              end else begin
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
                if (rs_q) begin
                  col_q <= col_q + 5'd1;
                end else if (byte_q[7]) begin
                  line_q <= byte_q[6];
                  col_q  <= byte_q[4:0];
                end else if (byte_q == CMD_CLEAR || byte_q == CMD_HOME) begin
                  line_q <= 1'b0;
                  col_q  <= '0;
                end
              end
`else
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
`endif
            end
          endcase
        end
        ST_IDLE: if (bus.iWrite) begin
          ready_q <= 1'b0;
          byte_q  <= bus.iData;
          rs_q    <= bus.iRS;
          state_q <= ST_WRITE;
          phase_q <= PH_START;
        end
        default: state_q <= ST_PWRUP;
      endcase
    end
  end

  lcd_nibble_writer #(
    .P_SETUP   (P_SETUP),
    .P_E_PULSE (P_E_PULSE)
  ) u_nibble (
    .Clock               (Clock),
    .Reset               (Reset),
    .iStart              (nib_start),
    .iNibble             (nib_data),
    .iRS                 (rs_q),
    .oDone               (nib_done),
    .oLCD_Enabled        (oLCD_Enabled),
    .oLCD_RegisterSelect (oLCD_RegisterSelect),
    .oLCD_Data           (oLCD_Data)
  );

  assign bus.oReady              = ready_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_controller.sv
// Scoreboard bench for lcd_controller: expected {RS,nibble} pushed per write,
// popped by a monitor on every E rise. Define LCD_AUTO_WRAP_EN to add the wrap test.
module tb_lcd_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e, lcd_rs, lcd_rw, lcd_sf;
  logic [3:0] lcd_d;

  lcd_controller_if bus();

  lcd_controller #(
    .P_POWERUP    (20),
    .P_WAIT_4MS   (10),
    .P_WAIT_100US (8),
    .P_WAIT_40US  (5),
    .P_WAIT_CLEAR (15)
  ) dut (
    .Clock                   (clk),
    .Reset                   (rst),
    .bus                     (bus),
    .oLCD_Enabled            (lcd_e),
    .oLCD_RegisterSelect     (lcd_rs),
    .oLCD_ReadWrite          (lcd_rw),
    .oLCD_StrataFlashControl (lcd_sf),
    .oLCD_Data               (lcd_d)
  );

  always #5 clk = ~clk;

  // Power-up 20 + init 4*16+(10+8+5+5) + config 4*80+(5+5+5+15) cycles.
  localparam int INIT_CYCLES  = 462;
  // Capture to oReady: 2*(2+12+1) + 50 + wait.
  localparam int BYTE_CYCLES  = 85;
  localparam int CLEAR_CYCLES = 95;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_byte(input logic r, input logic [7:0] b);
    exp_q.push_back({r, b[7:4]});
    exp_q.push_back({r, b[3:0]});
  endtask

  task automatic push_init();
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (bus.oReady !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Ends #1 after the capture edge.
  task automatic write_start(input logic r, input logic [7:0] b, input bit has_ins,
                             input logic [7:0] ins, input string name);
    int n;
    wait_ready(400, n);
    check({name, "_ready_before"}, bus.oReady, 1);
    push_byte(r, b);
    if (has_ins) push_byte(1'b0, ins);
    bus.iWrite = 1'b1;
    bus.iRS    = r;
    bus.iData  = b;
    @(posedge clk); #1;
    bus.iWrite = 1'b0;
    $display("write rs=%0b data=%02h", r, b);
    check({name, "_ready_drop"}, bus.oReady, 0);
  endtask

  task automatic write_finish(input int exp_len, input bit spur, input string name);
    int n;
    n = 0;
    if (spur) begin
      bus.iRS   = 1'b1;
      bus.iData = 8'h77;
    end
    while (bus.oReady !== 1'b1 && n < 400) begin
      if (spur) bus.iWrite = (n >= 20 && n < 23);
      @(posedge clk); #1;
      n++;
    end
    bus.iWrite = 1'b0;
    check({name, "_busy_len"}, n, exp_len);
  endtask

  // Monitor: every E rise must match the oldest expected nibble.
  initial begin
    logic       prev_e;
    logic [4:0] exp;
    prev_e = 1'b0;
    forever begin
      @(negedge clk);
      if (lcd_e === 1'b1 && prev_e === 1'b0) begin
        $display("pulse rs=%0b data=%h", lcd_rs, lcd_d);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected actual=%0b_%h required=none", lcd_rs, lcd_d);
        end else begin
          exp = exp_q.pop_front();
          if ({lcd_rs, lcd_d} !== exp) begin
            errors++;
            $display("FAIL pulse_nibble actual=%0b_%h required=%0b_%h", lcd_rs, lcd_d, exp[4], exp[3:0]);
          end
        end
        checks++;
        if (lcd_rw !== 1'b0 || lcd_sf !== 1'b1) begin
          errors++;
          $display("FAIL pulse_rw_sf actual=%0b%0b required=01", lcd_rw, lcd_sf);
        end
      end
      prev_e = lcd_e;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    bus.iWrite = 1'b0;
    bus.iRS    = 1'b0;
    bus.iData  = 8'h00;
    push_init();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.oReady, 0);
    check("rst_e", lcd_e, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_sf", lcd_sf, 1);
    check("rst_data", lcd_d, 0);
    rst = 1'b0;
    wait_ready(2000, n);
    check("init_cycles", n, INIT_CYCLES);
    check("init_queue_empty", exp_q.size(), 0);

    write_start(1'b1, 8'h48, 1'b0, 8'h00, "data48");
    write_finish(BYTE_CYCLES, 1'b0, "data48");

    write_start(1'b0, 8'h01, 1'b0, 8'h00, "clear");
    write_finish(CLEAR_CYCLES, 1'b0, "clear");

    write_start(1'b0, 8'h02, 1'b0, 8'h00, "home");
    write_finish(CLEAR_CYCLES, 1'b0, "home");

    write_start(1'b1, 8'h33, 1'b0, 8'h00, "ignored");
    write_finish(BYTE_CYCLES, 1'b1, "ignored");
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.oReady !== 1'b1) n++;
    end
    check("idle_no_write_ready_low", n, 0);
    check("idle_no_write_queue", exp_q.size(), 0);

    // Reset while E is high on a data byte.
    write_start(1'b1, 8'h5A, 1'b0, 8'h00, "rstmid");
    n = 0;
    while (lcd_e !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_e_rise", n, 3);
    @(negedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("rstmid_e_low", lcd_e, 0);
    check("rstmid_ready", bus.oReady, 0);
    push_init();
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(2000, n);
    check("reinit_cycles", n, INIT_CYCLES);
    check("reinit_queue_empty", exp_q.size(), 0);

`ifdef LCD_AUTO_WRAP_EN
    for (int i = 1; i <= 33; i++) begin
      bit ins;
      ins = (i == 16) || (i == 32);
      write_start(1'b1, 8'h41, ins, (i == 16) ? 8'hC0 : 8'h80, $sformatf("wrap%0d", i));
      write_finish(ins ? 2 * BYTE_CYCLES : BYTE_CYCLES, 1'b0, $sformatf("wrap%0d", i));
    end
    check("wrap_queue_empty", exp_q.size(), 0);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("end_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
